pipeline_stall_controller: RTL and testbench

Central pipeline-control responder for the 5-stage core. It consumes the load-use hazard request from the stall detection unit, the EX-stage branch-taken flush request and the data-memory ready handshake. From these it drives every pipeline-register write enable, flush and bubble select.
It also owns the multi-cycle memory-wait FSM, a memory-wait watchdog and saturating performance counters for stall, flush and wait cycles.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_stall_controller.sv | 143 ++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline stall controller.
//   state_t : memory-wait FSM states
//   ctrl_t  : the seven pipeline enable/flush/bubble controls
//   CTRL_*  : control pattern for each pipeline condition
package pipe_ctrl_pkg;

    localparam int unsigned TMR_W = 10;   // holds MEM_TIMEOUT up to 1023

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_ctrl_sel;
        logic ex_mem_we;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                      id_ex_we: 1'b1, id_ex_ctrl_sel: 1'b1,
                                      ex_mem_we: 1'b1, mem_wb_bubble: 1'b0};

    localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_we: 1'b0, id_ex_ctrl_sel: 1'b1,
                                      ex_mem_we: 1'b0, mem_wb_bubble: 1'b1};

    localparam ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                     id_ex_we: 1'b1, id_ex_ctrl_sel: 1'b0,
                                     ex_mem_we: 1'b1, mem_wb_bubble: 1'b0};

    localparam ctrl_t CTRL_LOADUSE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                       id_ex_we: 1'b1, id_ex_ctrl_sel: 1'b0,
                                       ex_mem_we: 1'b1, mem_wb_bubble: 1'b0};

    localparam ctrl_t CTRL_HALT = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                    id_ex_we: 1'b0, id_ex_ctrl_sel: 1'b0,
                                    ex_mem_we: 1'b0, mem_wb_bubble: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one this cycle
//   clr        : synchronous clear, wins over inc
//   cnt        : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Purpose: central pipeline-control responder for the 5-stage core.
//   Inputs : hazard_clk_gate (0 = load-use stall), branch_taken_ex,
//            dmem_req/dmem_ready handshake, cnt_clr
//   Outputs: pipeline write enables, IF/ID flush, ID/EX bubble select and
//            MEM/WB bubble (same-cycle), mem_wait, sticky mem_timeout_err,
//            saturating stall/flush/wait performance counters
module pipeline_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_clk_gate,
    input  logic             branch_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_ctrl_sel,
    output logic             ex_mem_we,
    output logic             mem_wb_bubble,
    output logic             mem_wait,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl_out_c;
    logic             freeze_c;
    logic             stall_inc_c, flush_inc_c, wait_inc_c;

    // A pending access that memory has not completed freezes the pipe;
    // dmem_req dropping releases WAIT exactly like dmem_ready does.
    assign freeze_c = dmem_req & ~dmem_ready;

    // State, watchdog timer and sticky error register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            timer           <= '0;
            mem_wait        <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            mem_wait        <= (state_nxt == WAIT);
            mem_timeout_err <= mem_timeout_err | (state_nxt == ERR);
        end
    end

    // Next-state, control selection and counter increments
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        ctrl_c      = CTRL_NORMAL;
        stall_inc_c = 1'b0;
        flush_inc_c = 1'b0;
        wait_inc_c  = 1'b0;

        case (state)
            RUN: begin
                if (freeze_c) begin
                    state_nxt = WAIT;
                    timer_nxt = TMR_W'(1);
                end
            end
            WAIT: begin
                if (!freeze_c) begin
                    state_nxt = RUN;
                end else if (timer == TMR_W'(MEM_TIMEOUT)) begin
                    state_nxt = ERR;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Priority: ERR > freeze > branch flush > load-use > normal
        if (state == ERR) begin
            ctrl_c = CTRL_HALT;
        end else if (freeze_c) begin
            ctrl_c     = CTRL_FREEZE;
            wait_inc_c = 1'b1;
        end else if (branch_taken_ex) begin
            ctrl_c      = CTRL_FLUSH;
            flush_inc_c = 1'b1;
        end else if (!hazard_clk_gate) begin
            ctrl_c      = CTRL_LOADUSE;
            stall_inc_c = 1'b1;
        end
    end

    // Every control is held low while reset is asserted
    assign ctrl_out_c = rst_n ? ctrl_c : '0;

    assign pc_we          = ctrl_out_c.pc_we;
    assign if_id_we       = ctrl_out_c.if_id_we;
    assign if_id_flush    = ctrl_out_c.if_id_flush;
    assign id_ex_we       = ctrl_out_c.id_ex_we;
    assign id_ex_ctrl_sel = ctrl_out_c.id_ex_ctrl_sel;
    assign ex_mem_we      = ctrl_out_c.ex_mem_we;
    assign mem_wb_bubble  = ctrl_out_c.mem_wb_bubble;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_c),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_c),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc_c),
        .clr   (cnt_clr),
        .cnt   (wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Purpose: self-checking bench for pipeline_stall_controller
// (small counters and short watchdog to reach the corner cases quickly).
module tb_pipeline_stall_controller;

    localparam int unsigned CNT_W       = 3;
    localparam int unsigned MEM_TIMEOUT = 4;

    // Expected control patterns, bit order:
    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_ctrl_sel, ex_mem_we, mem_wb_bubble}
    localparam logic [6:0] P_NORMAL  = 7'b1101110;
    localparam logic [6:0] P_FREEZE  = 7'b0000101;
    localparam logic [6:0] P_FLUSH   = 7'b1111010;
    localparam logic [6:0] P_LOADUSE = 7'b0001010;
    localparam logic [6:0] P_HALT    = 7'b0000001;
    localparam logic [6:0] P_ZERO    = 7'b0000000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hazard_clk_gate, branch_taken_ex, dmem_req, dmem_ready, cnt_clr;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_ctrl_sel;
    logic             ex_mem_we, mem_wb_bubble, mem_wait, mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
    logic [6:0]       ctrl_act;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [6:0] ctrl;
        logic       wait_exp;
    } exp_t;

    typedef struct {
        logic       h;
        logic       b;
        logic       rq;
        logic       rd;
        logic [6:0] ctrl;
        logic       wait_exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    assign ctrl_act = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_ctrl_sel,
                       ex_mem_we, mem_wb_bubble};

    pipeline_stall_controller #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_clk_gate (hazard_clk_gate),
        .branch_taken_ex (branch_taken_ex),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .cnt_clr         (cnt_clr),
        .pc_we           (pc_we),
        .if_id_we        (if_id_we),
        .if_id_flush     (if_id_flush),
        .id_ex_we        (id_ex_we),
        .id_ex_ctrl_sel  (id_ex_ctrl_sel),
        .ex_mem_we       (ex_mem_we),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_wait        (mem_wait),
        .mem_timeout_err (mem_timeout_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wait_cnt        (wait_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs (caller sits just after a rising edge),
    // queue the expectation, compare on the falling edge, advance.
    task automatic drive(input logic h, input logic b, input logic rq, input logic rd,
                         input logic cl, input logic [6:0] ec, input logic ew,
                         input string nm);
        exp_t e;
        hazard_clk_gate = h;
        branch_taken_ex = b;
        dmem_req        = rq;
        dmem_ready      = rd;
        cnt_clr         = cl;
        sb.push_back('{name: nm, ctrl: ec, wait_exp: ew});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, " ctrl"}, 32'(ctrl_act), 32'(e.ctrl));
        chk({e.name, " mem_wait"}, 32'(mem_wait), 32'(e.wait_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string nm, input int s, input int f, input int w);
        chk({nm, " stall_cnt"}, 32'(stall_cnt), 32'(s));
        chk({nm, " flush_cnt"}, 32'(flush_cnt), 32'(f));
        chk({nm, " wait_cnt"},  32'(wait_cnt),  32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                 h     b     rq    rd    ctrl       wait
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, P_NORMAL,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, P_LOADUSE, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, P_FLUSH,   1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, P_FLUSH,   1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, P_NORMAL,  1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, P_FREEZE,  1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, P_LOADUSE, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, P_FREEZE,  1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, P_FLUSH,   1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, P_FREEZE,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, P_NORMAL,  1'b1};

        // Reset held with load-use and an unfinished access pending
        rst_n           = 1'b0;
        hazard_clk_gate = 1'b0;
        branch_taken_ex = 1'b0;
        dmem_req        = 1'b1;
        dmem_ready      = 1'b0;
        cnt_clr         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctrl", 32'(ctrl_act), 32'(P_ZERO));
        chk("reset mem_wait", 32'(mem_wait), 32'd0);
        chk("reset err", 32'(mem_timeout_err), 32'd0);
        chk_cnts("reset", 0, 0, 0);

        rst_n = 1'b1;
        #1;
        chk("post-reset ctrl", 32'(ctrl_act), 32'(P_FREEZE));
        chk("post-reset mem_wait", 32'(mem_wait), 32'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b1, "rst_freeze2");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_NORMAL, 1'b1, "rst_release");
        chk_cnts("after rst freeze", 0, 0, 2);
        chk("after release mem_wait", 32'(mem_wait), 32'd0);

        // Table of single-cycle patterns
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr0");
        chk_cnts("clr0", 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].h, vecs[i].b, vecs[i].rq, vecs[i].rd, 1'b0,
                  vecs[i].ctrl, vecs[i].wait_exp, $sformatf("vec%0d", i));
        end
        chk_cnts("table", 2, 3, 3);

        // Single load-use cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr1");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_LOADUSE, 1'b0, "loaduse1");
        chk_cnts("loaduse1", 1, 0, 0);

        // Branch beats simultaneous load-use
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr2");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, P_FLUSH, 1'b0, "br_lu");
        chk_cnts("br_lu", 0, 1, 0);

        // Three freeze cycles with a branch waiting, serviced on release
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr3");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b0, "frz_br0");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b1, "frz_br1");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b1, "frz_br2");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, P_FLUSH,  1'b1, "frz_rel");
        chk_cnts("frz_br", 0, 1, 3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_NORMAL, 1'b0, "frz_after");

        // Stall counter saturation, then clear beating increment
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr4");
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_LOADUSE, 1'b0, $sformatf("sat%0d", i));
        end
        chk("saturated stall_cnt", 32'(stall_cnt), 32'd7);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, P_LOADUSE, 1'b0, "sat_clr");
        chk("cleared stall_cnt", 32'(stall_cnt), 32'd0);

        // Memory-wait watchdog: error after the fourth WAIT cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, P_NORMAL, 1'b0, "clr5");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b0, "to0");
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b1, $sformatf("to%0d", i));
        end
        chk("err before timeout", 32'(mem_timeout_err), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, P_FREEZE, 1'b1, "to4");
        chk("err at timeout", 32'(mem_timeout_err), 32'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, P_HALT, 1'b0, "err_ready");
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, P_HALT, 1'b0, "err_branch");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, P_HALT, 1'b0, "err_loaduse");
        chk("err sticky", 32'(mem_timeout_err), 32'd1);
        chk_cnts("err", 0, 0, 5);

        // Only a reset pulse leaves ERR
        rst_n = 1'b0;
        #1;
        chk("err reset ctrl", 32'(ctrl_act), 32'(P_ZERO));
        chk("err reset flag", 32'(mem_timeout_err), 32'd0);
        chk("err reset wait_cnt", 32'(wait_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, P_NORMAL, 1'b0, "post_err_rst");
        chk("post_err_rst flag", 32'(mem_timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
